// File: rtl/reg_cmd_driver.sv
// Command-driven stimulus/response engine: applies one control word and data for one cycle, samples the target LAT cycles later and checks it.
// Optional first-failure log enabled by defining REG_CMD_DRIVER_FAIL_LOG_EN.
module reg_cmd_driver #(
  parameter int DATA_W = 4,
  parameter int CTRL_W = 3,
  parameter int LAT    = 1,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CTRL_W-1:0] cmd_ctrl,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_exp,
  input  logic              cmd_chk,
  output logic [CTRL_W-1:0] control,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  output logic              rsp_valid,
  output logic              rsp_pass,
  output logic [DATA_W-1:0] rsp_actual,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  cmd_cnt,
  output logic              busy
`ifdef REG_CMD_DRIVER_FAIL_LOG_EN
  ,
  output logic              first_fail_valid,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [DATA_W-1:0] first_fail_act
`endif
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  state_t            state, next;
  logic [3:0]        wait_cnt;
  logic [CTRL_W-1:0] cap_ctrl;
  logic [DATA_W-1:0] cap_data;
  logic [DATA_W-1:0] cap_exp;
  logic              cap_chk;
  logic              accept;
  logic              sample;
  logic              pass_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept   = cmd_valid && cmd_ready;
  assign sample   = (state == WAIT) && (wait_cnt == 4'd0);
  assign pass_now = !cap_chk || (data_out == cap_exp);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) next = DRIVE;
      end
      DRIVE:   next = WAIT;
      WAIT:    if (wait_cnt == 4'd0) next = IDLE;
      default: next = IDLE;
    endcase
  end

  // Command capture: only meaningful while a command is in flight, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      cap_ctrl <= cmd_ctrl;
      cap_data <= cmd_data;
      cap_exp  <= cmd_exp;
      cap_chk  <= cmd_chk;
    end
  end

  // Accept edge -> drive cycle; sample edge -> response and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      control    <= '0;
      data_in    <= '0;
      wait_cnt   <= '0;
      rsp_valid  <= 1'b0;
      rsp_pass   <= 1'b0;
      rsp_actual <= '0;
      err_cnt    <= '0;
      cmd_cnt    <= '0;
    end else begin
      control   <= '0;
      data_in   <= '0;
      rsp_valid <= 1'b0;
      if (accept) begin
        control <= cmd_ctrl;
        data_in <= cmd_data;
      end
      if (state == DRIVE)
        wait_cnt <= LAT_M1;
      else if (state == WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 1'b1;
      if (sample) begin
        rsp_valid  <= 1'b1;
        rsp_pass   <= pass_now;
        rsp_actual <= data_out;
        cmd_cnt    <= cmd_cnt + 1'b1;
        if (!pass_now) err_cnt <= sat_inc(err_cnt);
      end
    end
  end

  // cap_ctrl is captured for visibility of the applied command; the drive path uses the live input at accept.
  logic unused_ctrl;
  assign unused_ctrl = ^{cap_ctrl, cap_data};

`ifdef REG_CMD_DRIVER_FAIL_LOG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
      first_fail_exp   <= '0;
      first_fail_act   <= '0;
    end else if (sample && !pass_now && !first_fail_valid) begin
      first_fail_valid <= 1'b1;
      first_fail_idx   <= cmd_cnt;
      first_fail_exp   <= cap_exp;
      first_fail_act   <= data_out;
    end
  end
`endif

endmodule
